// File: rtl/tv_code_sequencer_if.sv
// Bundles the sequencer's control, status and ROM-side signals.
// The master modport is the sequencer; the slave modport is the surrounding system and ROM.
interface tv_code_sequencer_if #(
    parameter int ADDRESS_BITS = 10
);
    logic                    start;
    logic                    stop;
    logic [ADDRESS_BITS-1:0] rom_address;
    logic [7:0]              rom_data;
    logic                    rom_overflow;
    logic                    ir_out;
    logic                    busy;
    logic                    done;
    logic                    truncated;
    logic [7:0]              code_count;

    modport master (
        input  start, stop, rom_data, rom_overflow,
        output rom_address, ir_out, busy, done, truncated, code_count
    );

    modport slave (
        output start, stop, rom_data, rom_overflow,
        input  rom_address, ir_out, busy, done, truncated, code_count
    );
endinterface

// File: rtl/tv_code_sequencer.sv
// Walks the TV-codes ROM from address 0 and plays each entry as carrier-modulated IR.
// Entry layout: carrier half-period C (0 ends the table), pair count N, then N (on, off) unit pairs.
module tv_code_sequencer #(
    parameter int ROM_SIZE  = 1000,
    parameter int TICK_DIV  = 120,
    parameter int GAP_UNITS = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    tv_code_sequencer_if.master bus
);
    localparam int ADDRESS_BITS = $clog2(ROM_SIZE);
    localparam int GAP_CYCLES   = GAP_UNITS * TICK_DIV;
    localparam int GAP_BITS     = $clog2(GAP_CYCLES + 1);
    // Mark/space products need 24 bits; widen only if the inter-code gap needs more.
    localparam int TIMER_BITS   = (GAP_BITS > 24) ? GAP_BITS : 24;

    localparam logic [ADDRESS_BITS-1:0] ADDR_ONE   = ADDRESS_BITS'(1);
    localparam logic [TIMER_BITS-1:0]   TIMER_ONE  = TIMER_BITS'(1);
    localparam logic [TIMER_BITS-1:0]   TIMER_ZERO = TIMER_BITS'(0);
    localparam logic [TIMER_BITS-1:0]   TICK_DIV_T = TIMER_BITS'(TICK_DIV);
    localparam logic [TIMER_BITS-1:0]   GAP_LOAD   = TIMER_BITS'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_CARRIER,
        HDR_COUNT,
        LOAD_ON,
        MARK,
        LOAD_OFF,
        SPACE,
        GAP
    } state_t;

    state_t                  state_r, state_next_s;
    logic [ADDRESS_BITS-1:0] addr_r, addr_next_s;
    logic [7:0]              carrier_r, carrier_next_s;
    logic [7:0]              phase_r, phase_next_s;
    logic [7:0]              pairs_r, pairs_next_s;
    logic [TIMER_BITS-1:0]   timer_r, timer_next_s;
    logic [TIMER_BITS-1:0]   unit_cycles_s;
    logic [7:0]              count_r, count_next_s, count_inc_s;
    logic                    ir_r, ir_next_s;
    logic                    done_r, done_next_s;
    logic                    trunc_r, trunc_next_s;
    logic                    busy_r, busy_next_s;

    assign unit_cycles_s = TIMER_BITS'(bus.rom_data) * TICK_DIV_T;
    assign count_inc_s   = (count_r == 8'hFF) ? count_r : count_r + 8'd1;
    assign busy_next_s   = (state_next_s != IDLE);

    // Next-state, datapath and output decode for the table walker.
    always_comb begin
        state_next_s   = state_r;
        addr_next_s    = addr_r;
        carrier_next_s = carrier_r;
        phase_next_s   = phase_r;
        pairs_next_s   = pairs_r;
        timer_next_s   = timer_r;
        count_next_s   = count_r;
        trunc_next_s   = trunc_r;
        ir_next_s      = 1'b0;
        done_next_s    = 1'b0;
        if (bus.stop && (state_r != IDLE)) begin
            state_next_s = IDLE;
            done_next_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_next_s = HDR_CARRIER;
                        addr_next_s  = {ADDRESS_BITS{1'b0}};
                        count_next_s = 8'd0;
                        trunc_next_s = 1'b0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                HDR_CARRIER: begin
                    if (bus.rom_overflow || (bus.rom_data == 8'd0)) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        carrier_next_s = bus.rom_data;
                        addr_next_s    = addr_r + ADDR_ONE;
                        state_next_s   = HDR_COUNT;
                    end
                end
                HDR_COUNT: begin
                    if (bus.rom_overflow) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                        trunc_next_s = 1'b1;
                    end else if (bus.rom_data == 8'd0) begin
                        addr_next_s  = addr_r + ADDR_ONE;
                        state_next_s = HDR_CARRIER;
                    end else begin
                        pairs_next_s = bus.rom_data;
                        addr_next_s  = addr_r + ADDR_ONE;
                        state_next_s = LOAD_ON;
                    end
                end
                LOAD_ON: begin
                    if (bus.rom_overflow) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                        trunc_next_s = 1'b1;
                    end else if (bus.rom_data == 8'd0) begin
                        addr_next_s  = addr_r + ADDR_ONE;
                        state_next_s = LOAD_OFF;
                    end else begin
                        addr_next_s  = addr_r + ADDR_ONE;
                        timer_next_s = unit_cycles_s - TIMER_ONE;
                        phase_next_s = 8'd1;
                        ir_next_s    = 1'b1;
                        state_next_s = MARK;
                    end
                end
                MARK: begin
                    if (timer_r == TIMER_ZERO) begin
                        state_next_s = LOAD_OFF;
                    end else if (phase_r == carrier_r) begin
                        timer_next_s = timer_r - TIMER_ONE;
                        phase_next_s = 8'd1;
                        ir_next_s    = ~ir_r;
                    end else begin
                        timer_next_s = timer_r - TIMER_ONE;
                        phase_next_s = phase_r + 8'd1;
                        ir_next_s    = ir_r;
                    end
                end
                LOAD_OFF: begin
                    if (bus.rom_overflow) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                        trunc_next_s = 1'b1;
                    end else if (bus.rom_data != 8'd0) begin
                        addr_next_s  = addr_r + ADDR_ONE;
                        pairs_next_s = pairs_r - 8'd1;
                        timer_next_s = unit_cycles_s - TIMER_ONE;
                        state_next_s = SPACE;
                    end else if (pairs_r == 8'd1) begin
                        // Zero-length space on the last pair: finish the code right here.
                        addr_next_s  = addr_r + ADDR_ONE;
                        pairs_next_s = 8'd0;
                        count_next_s = count_inc_s;
                        timer_next_s = GAP_LOAD;
                        state_next_s = GAP;
                    end else begin
                        addr_next_s  = addr_r + ADDR_ONE;
                        pairs_next_s = pairs_r - 8'd1;
                        state_next_s = LOAD_ON;
                    end
                end
                SPACE: begin
                    if (timer_r != TIMER_ZERO) begin
                        timer_next_s = timer_r - TIMER_ONE;
                    end else if (pairs_r == 8'd0) begin
                        count_next_s = count_inc_s;
                        timer_next_s = GAP_LOAD;
                        state_next_s = GAP;
                    end else begin
                        state_next_s = LOAD_ON;
                    end
                end
                GAP: begin
                    if (timer_r == TIMER_ZERO) begin
                        state_next_s = HDR_CARRIER;
                    end else begin
                        timer_next_s = timer_r - TIMER_ONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; every output comes straight from one of these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= {ADDRESS_BITS{1'b0}};
            carrier_r <= 8'd0;
            phase_r   <= 8'd0;
            pairs_r   <= 8'd0;
            timer_r   <= TIMER_ZERO;
            count_r   <= 8'd0;
            trunc_r   <= 1'b0;
            ir_r      <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            addr_r    <= addr_next_s;
            carrier_r <= carrier_next_s;
            phase_r   <= phase_next_s;
            pairs_r   <= pairs_next_s;
            timer_r   <= timer_next_s;
            count_r   <= count_next_s;
            trunc_r   <= trunc_next_s;
            ir_r      <= ir_next_s;
            done_r    <= done_next_s;
            busy_r    <= busy_next_s;
        end
    end

    assign bus.rom_address = addr_r;
    assign bus.ir_out      = ir_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.truncated   = trunc_r;
    assign bus.code_count  = count_r;
endmodule

// File: tb/tb_tv_code_sequencer.sv
// Self-checking bench: a behavioural ROM plus a table-walking waveform model that predicts
// ir_out/busy/done per cycle and the end-of-pass status for directed and random tables.
module tb_tv_code_sequencer;
    localparam int ROM_BYTES = 2048;
    localparam int AB        = 11;
    localparam int TD        = 4;
    localparam int GAP_U     = 1;

    logic clk;
    logic rst_n;
    logic [7:0] rom [0:ROM_BYTES-1];
    int rom_len;
    int rom_limit;

    int n_checks;
    int n_fail;

    bit exp_ir [$];
    int exp_count;
    int exp_addr;
    bit exp_trunc;

    tv_code_sequencer_if #(.ADDRESS_BITS(AB)) bus ();

    tv_code_sequencer #(
        .ROM_SIZE (ROM_BYTES),
        .TICK_DIV (TD),
        .GAP_UNITS(GAP_U)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational codes ROM with a movable end so overflow can be provoked anywhere.
    always_comb begin
        if (int'(bus.rom_address) < rom_limit) begin
            bus.rom_data     = rom[bus.rom_address];
            bus.rom_overflow = 1'b0;
        end else begin
            bus.rom_data     = 8'h00;
            bus.rom_overflow = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'h00;
        rom_len   = 0;
        rom_limit = ROM_BYTES;
    endtask

    task automatic push_byte(input int v);
        rom[rom_len] = 8'(v);
        rom_len++;
    endtask

    // Expected waveform: one entry per cycle from the first cycle after start until done.
    task automatic build_model();
        int addr, c, n, on, off, count;
        bit trunc, abort;
        exp_ir.delete();
        addr  = 0;
        count = 0;
        trunc = 1'b0;
        abort = 1'b0;
        while (!abort) begin
            exp_ir.push_back(1'b0);
            if (addr >= rom_limit || rom[addr] == 8'd0) break;
            c = int'(rom[addr]);
            addr++;
            exp_ir.push_back(1'b0);
            if (addr >= rom_limit) begin trunc = 1'b1; break; end
            n = int'(rom[addr]);
            addr++;
            for (int p = 0; p < n; p++) begin
                exp_ir.push_back(1'b0);
                if (addr >= rom_limit) begin trunc = 1'b1; abort = 1'b1; break; end
                on = int'(rom[addr]);
                addr++;
                for (int i = 0; i < on * TD; i++) exp_ir.push_back(((i / c) % 2) == 0);
                exp_ir.push_back(1'b0);
                if (addr >= rom_limit) begin trunc = 1'b1; abort = 1'b1; break; end
                off = int'(rom[addr]);
                addr++;
                for (int i = 0; i < off * TD; i++) exp_ir.push_back(1'b0);
            end
            if (!abort && n > 0) begin
                if (count < 255) count++;
                for (int i = 0; i < GAP_U * TD; i++) exp_ir.push_back(1'b0);
            end
        end
        exp_count = count;
        exp_addr  = addr;
        exp_trunc = trunc;
    endtask

    // Starts a pass from IDLE (called #1 after a rising edge) and checks it cycle by cycle.
    task automatic run_pass(input string tag, input bit rand_start);
        build_model();
        bus.start = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, " trunc_clear"}, 32'(bus.truncated), 32'd0);
        check_eq({tag, " addr_start"}, 32'(bus.rom_address), 32'd0);
        for (int i = 0; i < exp_ir.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check_eq($sformatf("%s trace[%0d]", tag, i),
                     {29'd0, bus.busy, bus.done, bus.ir_out}, {29'd0, 1'b1, 1'b0, exp_ir[i]});
            bus.start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq({tag, " end_flags"}, {29'd0, bus.busy, bus.done, bus.ir_out}, 32'b010);
        check_eq({tag, " code_count"}, 32'(bus.code_count), 32'(exp_count));
        check_eq({tag, " truncated"}, 32'(bus.truncated), 32'(exp_trunc));
        check_eq({tag, " end_addr"}, 32'(bus.rom_address), 32'(exp_addr));
        @(posedge clk); #1;
        check_eq({tag, " done_once"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        clear_rom();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 {bus.rom_address, bus.code_count, bus.truncated, bus.busy, bus.done, bus.ir_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_outputs", {29'd0, bus.busy, bus.done, bus.ir_out}, 32'd0);

        clear_rom();
        push_byte(38); push_byte(1); push_byte(2); push_byte(3); push_byte(0);
        run_pass("basic", 1'b0);

        clear_rom();
        push_byte(10); push_byte(0); push_byte(20); push_byte(1); push_byte(1); push_byte(0); push_byte(0);
        run_pass("skip_zero_off", 1'b0);

        clear_rom();
        push_byte(10); push_byte(2); push_byte(5); push_byte(5);
        rom_limit = 4;
        run_pass("overflow", 1'b0);
        check_eq("overflow_sticky", 32'(bus.truncated), 32'd1);

        // Abort in the middle of a long mark.
        clear_rom();
        push_byte(38); push_byte(1); push_byte(200); push_byte(3); push_byte(0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("stop trunc_clear", 32'(bus.truncated), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_eq("stop pre_ir", {30'd0, bus.busy, bus.ir_out}, 32'b11);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        check_eq("stop flags", {29'd0, bus.busy, bus.done, bus.ir_out}, 32'b010);
        check_eq("stop addr", 32'(bus.rom_address), 32'd3);
        check_eq("stop count", 32'(bus.code_count), 32'd0);
        @(posedge clk); #1;
        check_eq("stop after", {30'd0, bus.busy, bus.done}, 32'd0);

        clear_rom();
        push_byte(38); push_byte(1); push_byte(2); push_byte(3); push_byte(0);
        run_pass("restart", 1'b0);

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(posedge clk); #1;
        check_eq("idle start_stop", {30'd0, bus.busy, bus.done}, 32'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Asynchronous reset while in a space.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("pre_reset state", {22'd0, bus.rom_address[2:0], bus.busy, bus.ir_out}, {22'd0, 3'd4, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {bus.rom_address, bus.code_count, bus.truncated, bus.busy, bus.done, bus.ir_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("post_reset_quiet[%0d]", i), {30'd0, bus.busy, bus.done}, 32'd0);
        end

        clear_rom();
        for (int i = 0; i < 300; i++) begin
            push_byte(2); push_byte(1); push_byte(1); push_byte(1);
        end
        push_byte(0);
        run_pass("saturate", 1'b0);

        for (int r = 0; r < 10; r++) begin
            int ncodes, npairs;
            clear_rom();
            ncodes = $urandom_range(1, 3);
            for (int k = 0; k < ncodes; k++) begin
                push_byte($urandom_range(1, 6));
                npairs = $urandom_range(0, 3);
                push_byte(npairs);
                for (int p = 0; p < npairs; p++) begin
                    push_byte($urandom_range(0, 5));
                    push_byte($urandom_range(0, 5));
                end
            end
            push_byte(0);
            if ($urandom_range(0, 2) == 0) rom_limit = $urandom_range(1, rom_len);
            run_pass($sformatf("rand%0d", r), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tv_code_sequencer.md
# tv_code_sequencer

Walks the TV-codes ROM from address 0 and turns each stored code entry into a carrier-modulated IR output. Parses entry headers and on/off pairs, times marks and spaces in tick units, and generates the carrier during marks. Sits directly downstream of the combinational codes ROM: it drives the ROM address and consumes the ROM data and overflow flag. Its `ir_out` feeds the IR LED driver.

## Interface
- `ROM_SIZE`, 1000: number of ROM bytes; must match the ROM instance.
- `ADDRESS_BITS`, $clog2(ROM_SIZE): localparam, ROM address width.
- `TICK_DIV`, 120: clk cycles per time unit (10 µs at 12 MHz); ≥ 1.
- `GAP_UNITS`, 20000: silence between codes, in time units; ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sampled in IDLE; begins a full table pass.
- `stop`  in  1  synchronous abort, effective in any state.
- `rom_address`  out  ADDRESS_BITS  ROM byte address, registered.
- `rom_data`  in  8  ROM byte at `rom_address`, valid in the same cycle.
- `rom_overflow`  in  1  ROM flag: address ≥ ROM_SIZE.
- `ir_out`  out  1  modulated IR drive, high = LED on.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a pass ends (table end, overflow or stop).
- `truncated`  out  1  sticky; set when overflow hits inside a code entry. Cleared on the next accepted start.
- `code_count`  out  8  codes fully transmitted in the current pass; saturates at 255.

## Operation
- ROM entry format, packed back to back:
  - byte C: carrier half-period in clk cycles; 0 = end of table.
  - byte N: pair count.
  - then N pairs of (on units, off units).
- States: IDLE, HDR_CARRIER, HDR_COUNT, LOAD_ON, MARK, LOAD_OFF, SPACE, GAP.
- Every byte-read state samples `rom_data`/`rom_overflow` at the current address and increments `rom_address` by 1 on exit. Exceptions: a C=0 exit or an overflow exit leaves the address unchanged.
- IDLE: on `start` → HDR_CARRIER. At the same time: address←0, code_count←0, truncated←0.
- HDR_CARRIER:
  - if `rom_overflow`, or C=0 → IDLE with `done` (truncated not set).
  - else latch C → HDR_COUNT.
- HDR_COUNT:
  - if overflow → IDLE, done, truncated←1.
  - if N=0 → HDR_CARRIER (code skipped, not counted, no gap).
  - else latch N → LOAD_ON.
- LOAD_ON:
  - overflow → IDLE, done, truncated←1.
  - on=0 → LOAD_OFF.
  - else → MARK for on×TICK_DIV cycles.
- MARK:
  - `ir_out`=1 in the first MARK cycle, then toggles every C cycles.
  - on exit → LOAD_OFF with `ir_out` low.
- LOAD_OFF:
  - overflow → IDLE, done, truncated←1.
  - decrement the pair counter.
  - off>0 → SPACE for off×TICK_DIV cycles.
  - off=0 → skip SPACE and go straight to the next-state decision.
- Next-state decision, after SPACE or a skipped SPACE:
  - pairs remain → LOAD_ON.
  - else code_count++ (saturating) → GAP.
- GAP: `ir_out`=0 for GAP_UNITS×TICK_DIV cycles → HDR_CARRIER.
- `stop`, any non-IDLE state: next cycle IDLE, `ir_out`=0, `done` pulse, address held, code_count held.
- `stop` and `start` together in IDLE: stop wins, no pass starts, no done.
- `start` while busy: ignored.
- `ir_out` is 0 in every state except MARK.

## Timing
- Reset values: rom_address=0, ir_out=0, busy=0, done=0, truncated=0, code_count=0, state=IDLE.
- Start latency: start sampled at edge k → HDR_CARRIER at k+1, HDR_COUNT k+2, LOAD_ON k+3. First `ir_out`=1 at k+4.
- Each byte-read state lasts exactly 1 cycle.
- MARK/SPACE: on or off units × TICK_DIV cycles, exact. Each unit byte needs a 24-bit cycle counter.
- Carrier period is 2C cycles.
  - Any partial half-period at the end of a MARK is truncated.
  - The carrier phase restarts high at every MARK.
- `done` asserts in the cycle the state returns to IDLE. `busy` deasserts in that same cycle.
- Reset asserted mid-pass: all outputs go to reset values asynchronously, with no done pulse.

## Test plan
- ROM {38,1,2,3,0}, TICK_DIV=4, GAP_UNITS=1, start at edge k:
  - ir_out rises at k+4 and toggles every 38 cycles until the 8-cycle MARK ends, i.e. high for 8 cycles.
  - then 12 cycles low, 4 gap cycles, then an end-of-table read.
  - done pulses once; code_count=1, truncated=0.
- ROM {10,0,20,1,1,0,0}: first code skipped, second transmitted, code_count=1. Pair (1,0) gives no SPACE cycles.
- ROM_SIZE=4, ROM {10,2,5,5}: overflow at LOAD_ON address 4 → done, truncated=1, code_count=0, ir_out low.
- `stop` asserted mid-MARK: ir_out=0 and busy=0 next cycle, done pulse. A new start clears truncated and restarts at address 0.
- rst_n low mid-SPACE: all outputs 0 immediately. After release, no done pulse until a new start.
- A table of 300 valid codes: code_count saturates at 255.
